// File: rtl/apb_st_reg_slice.sv
// APB-to-APB register slice: captures one upstream transfer, replays it downstream from
// registered outputs and returns the downstream response upstream for a single cycle.
// A downstream watchdog turns a slave that never answers into an error response.
module apb_st_reg_slice #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    // upstream (slave-side) port
    input  logic                    s_psel,
    input  logic                    s_penable,
    input  logic                    s_pwrite,
    input  logic [ADDR_WIDTH-1:0]   s_paddr,
    input  logic [DATA_WIDTH-1:0]   s_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_pstrb,
    input  logic [2:0]              s_pprot,
    output logic                    s_pready,
    output logic                    s_pslverr,
    output logic [DATA_WIDTH-1:0]   s_prdata,
    // downstream (master-side) port
    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [ADDR_WIDTH-1:0]   m_paddr,
    output logic [DATA_WIDTH-1:0]   m_pwdata,
    output logic [DATA_WIDTH/8-1:0] m_pstrb,
    output logic [2:0]              m_pprot,
    input  logic                    m_pready,
    input  logic                    m_pslverr,
    input  logic [DATA_WIDTH-1:0]   m_prdata,
    // watchdog abort pulse
    output logic                    timeout_o
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    // Keep the counter at least one bit wide so a disabled watchdog still elaborates.
    localparam int unsigned CntW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          WdogEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StMSetup,
        StMAccess,
        StResp
    } state_e;

    state_e                state_q,     state_d;
    logic [CntW-1:0]       cnt_q,       cnt_d;
    logic                  m_psel_q,    m_psel_d;
    logic                  m_penable_q, m_penable_d;
    logic                  m_pwrite_q,  m_pwrite_d;
    logic [ADDR_WIDTH-1:0] m_paddr_q,   m_paddr_d;
    logic [DATA_WIDTH-1:0] m_pwdata_q,  m_pwdata_d;
    logic [StrbW-1:0]      m_pstrb_q,   m_pstrb_d;
    logic [2:0]            m_pprot_q,   m_pprot_d;
    logic                  s_pready_q,  s_pready_d;
    logic                  s_pslverr_q, s_pslverr_d;
    logic [DATA_WIDTH-1:0] s_prdata_q,  s_prdata_d;
    logic                  timeout_q,   timeout_d;

    // Next-state logic; every output is computed one cycle ahead so it can come from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        m_pstrb_d   = m_pstrb_q;
        m_pprot_d   = m_pprot_q;
        s_pready_d  = 1'b0;
        s_pslverr_d = 1'b0;
        s_prdata_d  = '0;
        timeout_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Only a setup-phase sample starts a transfer; an access-phase sample is a
                // transfer that already completed and must not be replayed.
                if (s_psel && !s_penable) begin
                    state_d    = StMSetup;
                    m_psel_d   = 1'b1;
                    m_pwrite_d = s_pwrite;
                    m_paddr_d  = s_paddr;
                    m_pwdata_d = s_pwdata;
                    m_pstrb_d  = s_pstrb;
                    m_pprot_d  = s_pprot;
                end
            end
            StMSetup: begin
                // m_pready is deliberately ignored here.
                state_d     = StMAccess;
                cnt_d       = '0;
                m_psel_d    = 1'b1;
                m_penable_d = 1'b1;
            end
            StMAccess: begin
                if (m_pready) begin
                    // Normal completion takes priority over a watchdog expiry in the same cycle.
                    state_d     = StResp;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = m_pslverr;
                    s_prdata_d  = m_pwrite_q ? '0 : m_prdata;
                end else if (WdogEn && (cnt_q == CntLast)) begin
                    state_d     = StResp;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                    timeout_d   = 1'b1;
                end else begin
                    m_psel_d    = 1'b1;
                    m_penable_d = 1'b1;
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset clears everything, including captured request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            m_pstrb_q   <= '0;
            m_pprot_q   <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
            s_prdata_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            m_pstrb_q   <= m_pstrb_d;
            m_pprot_q   <= m_pprot_d;
            s_pready_q  <= s_pready_d;
            s_pslverr_q <= s_pslverr_d;
            s_prdata_q  <= s_prdata_d;
            timeout_q   <= timeout_d;
        end
    end

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwdata  = m_pwdata_q;
    assign m_pstrb   = m_pstrb_q;
    assign m_pprot   = m_pprot_q;
    assign s_pready  = s_pready_q;
    assign s_pslverr = s_pslverr_q;
    assign s_prdata  = s_prdata_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_st_reg_slice.sv
// Bench for apb_st_reg_slice: an upstream APB master task, a downstream slave with a
// programmable wait count, a downstream monitor, and a transfer-level reference model.
module tb_apb_st_reg_slice;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          s_psel, s_penable, s_pwrite;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata;
    logic [SW-1:0] s_pstrb;
    logic [2:0]    s_pprot;
    logic          s_pready, s_pslverr;
    logic [DW-1:0] s_prdata;
    logic          m_psel, m_penable, m_pwrite;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata;
    logic [SW-1:0] m_pstrb;
    logic [2:0]    m_pprot;
    logic          m_pready, m_pslverr;
    logic [DW-1:0] m_prdata;
    logic          timeout_o;

    always #5 clk = ~clk;

    apb_st_reg_slice #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_psel    (s_psel),
        .s_penable (s_penable),
        .s_pwrite  (s_pwrite),
        .s_paddr   (s_paddr),
        .s_pwdata  (s_pwdata),
        .s_pstrb   (s_pstrb),
        .s_pprot   (s_pprot),
        .s_pready  (s_pready),
        .s_pslverr (s_pslverr),
        .s_prdata  (s_prdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_pstrb   (m_pstrb),
        .m_pprot   (m_pprot),
        .m_pready  (m_pready),
        .m_pslverr (m_pslverr),
        .m_prdata  (m_prdata),
        .timeout_o (timeout_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All DUT outputs packed together, for the "everything is zero" checks.
    function automatic logic [127:0] all_outs();
        return 128'({s_pready, s_pslverr, s_prdata, m_psel, m_penable, m_pwrite, m_paddr,
                     m_pwdata, m_pstrb, m_pprot, timeout_o});
    endfunction

    // Downstream slave behaviour for the current transfer.
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;

    // Downstream slave: answers after slv_waits access cycles; noise on m_pready in setup.
    initial begin
        int acc;
        acc       = 0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        m_prdata  = '0;
        forever begin
            @(negedge clk);
            if (m_psel && m_penable) begin
                m_pready  = (acc == slv_waits);
                m_prdata  = slv_rdata;
                m_pslverr = slv_err;
                acc++;
            end else begin
                acc       = 0;
                m_pready  = m_psel ? 1'($urandom_range(0, 1)) : 1'b0;
                m_pslverr = m_psel ? 1'($urandom_range(0, 1)) : 1'b0;
                m_prdata  = $urandom;
            end
        end
    end

    // Downstream monitor: records every setup phase and counts access/timeout cycles.
    int          mon_setup    = 0;
    int          mon_access   = 0;
    int          mon_to       = 0;
    int          mon_unstable = 0;
    logic [71:0] mon_q[$];
    logic [71:0] last_req = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_psel && !m_penable) begin
                last_req = {m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot};
                mon_q.push_back(last_req);
                mon_setup++;
            end
            if (m_psel && m_penable) begin
                mon_access++;
                if ({m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot} !== last_req) begin
                    mon_unstable++;
                end
            end
            if (timeout_o) begin
                mon_to++;
            end
        end
    end

    // One upstream transfer, starting just after a rising edge, checked against the model.
    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int waits,
                            input logic [31:0] rdata, input logic err, input string tag);
        int          s0, a0, t0, u0, nw, exp_acc, exp_nw;
        logic        got_rdy, got_err, got_to, exp_to;
        logic [31:0] got_rd, exp_rd;
        logic [71:0] exp_req;
        slv_waits = waits;
        slv_rdata = rdata;
        slv_err   = err;
        s0 = mon_setup;
        a0 = mon_access;
        t0 = mon_to;
        u0 = mon_unstable;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_pwrite  = wr;
        s_paddr   = addr;
        s_pwdata  = wdata;
        s_pstrb   = strb;
        s_pprot   = prot;
        @(posedge clk);
        #1;
        s_penable = 1'b1;
        nw      = 0;
        got_rdy = 1'b0;
        got_err = 1'b0;
        got_to  = 1'b0;
        got_rd  = '0;
        while (!got_rdy && nw < 40) begin
            @(negedge clk);
            if (s_pready) begin
                got_rdy = 1'b1;
                got_rd  = s_prdata;
                got_err = s_pslverr;
                got_to  = timeout_o;
            end else begin
                nw++;
            end
            @(posedge clk);
            #1;
        end
        s_psel    = 1'b0;
        s_penable = 1'b0;

        // Reference: a slave slower than the watchdog allows is aborted after TO access cycles.
        exp_to  = (waits >= int'(TO));
        exp_acc = exp_to ? int'(TO) : waits + 1;
        exp_nw  = exp_acc + 1;
        exp_rd  = (exp_to || wr) ? 32'h0 : rdata;
        exp_req = {wr, addr, wdata, strb, prot};

        check_eq({tag, " done"},     128'(got_rdy), 128'(1'b1));
        check_eq({tag, " waits"},    128'(nw), 128'(exp_nw));
        check_eq({tag, " prdata"},   128'(got_rd), 128'(exp_rd));
        check_eq({tag, " pslverr"},  128'(got_err), 128'(exp_to ? 1'b1 : err));
        check_eq({tag, " to_resp"},  128'(got_to), 128'(exp_to));
        check_eq({tag, " to_count"}, 128'(mon_to - t0), 128'(exp_to ? 1 : 0));
        check_eq({tag, " setups"},   128'(mon_setup - s0), 128'(1));
        check_eq({tag, " accesses"}, 128'(mon_access - a0), 128'(exp_acc));
        check_eq({tag, " stable"},   128'(mon_unstable - u0), 128'(0));
        check_eq({tag, " q_size"},   128'(mon_q.size()), 128'(1));
        if (mon_q.size() > 0) begin
            check_eq({tag, " request"}, 128'(mon_q.pop_front()), 128'(exp_req));
        end
        mon_q.delete();
    endtask

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic        b_wr;
        int          b_w;
        logic [31:0] b_addr, b_wdata, b_rdata;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_pwrite  = 1'b0;
        s_paddr   = '0;
        s_pwdata  = '0;
        s_pstrb   = '0;
        s_pprot   = '0;

        // Reset for 5 cycles, then check everything stays quiet with upstream idle.
        #1 reset_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold outs", all_outs(), 128'(0));
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_idle outs", all_outs(), 128'(0));
        end
        @(posedge clk);
        #1;

        // An access-phase sample in idle must never start a transfer.
        begin
            int s0;
            s0 = mon_setup;
            s_psel    = 1'b1;
            s_penable = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            s_psel    = 1'b0;
            s_penable = 1'b0;
            check_eq("no_capture_access setups", 128'(mon_setup - s0), 128'(0));
        end

        run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 32'hA5A5_A5A5, 1'b0, "wr0");
        run_xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'd2, 3, 32'h1234_5678, 1'b1, "rd3err");
        run_xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'd1, 1000, 32'hFFFF_FFFF, 1'b0, "wdog");
        @(negedge clk);
        check_eq("wdog m_psel_after", 128'(m_psel), 128'(0));
        @(posedge clk);
        #1;
        run_xfer(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd0, int'(TO) - 1, 32'hCAFE_F00D, 1'b0,
                 "wdog_edge");
        run_xfer(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 4'h3, 3'd5, int'(TO), 32'h0, 1'b0,
                 "wdog_exact");

        // Back-to-back random mix.
        for (int i = 0; i < 20; i++) begin
            b_wr    = 1'($urandom_range(0, 1));
            b_addr  = $urandom;
            b_wdata = $urandom;
            b_rdata = $urandom;
            b_w     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(6, 10))
                                                  : int'($urandom_range(0, 3));
            run_xfer(b_wr, b_addr, b_wdata, 4'($urandom), 3'($urandom), b_w, b_rdata,
                     1'($urandom_range(0, 1)), $sformatf("b2b%0d", i));
        end

        // Transfer 21: reset lands in the downstream access phase.
        slv_waits = 5;
        slv_rdata = 32'h7777_7777;
        slv_err   = 1'b0;
        s_psel    = 1'b1;
        s_penable = 1'b0;
        s_pwrite  = 1'b1;
        s_paddr   = 32'h0000_0100;
        s_pwdata  = 32'h5555_AAAA;
        s_pstrb   = 4'hF;
        s_pprot   = 3'd3;
        @(posedge clk);
        #1;
        s_penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_mid in_access", 128'({m_psel, m_penable}), 128'(2'b11));
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid outs", all_outs(), 128'(0));
        s_psel    = 1'b0;
        s_penable = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_mid hold outs", all_outs(), 128'(0));
        reset_n = 1'b1;
        mon_q.delete();
        @(posedge clk);
        #1;
        run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd0, 2, 32'h0F0F_1234, 1'b0, "post_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
